// File: rtl/dffrnq_pipe.sv
// dffrnq_pipe: DEPTH-stage data pipeline with per-stage valid flags,
// hold, flush and a registered occupancy count.
// Optional parity tracking per stage is built when DFFRNQ_PIPE_PARITY_EN
// is defined; otherwise PERR is tied low and no parity storage exists.
module dffrnq_pipe #(
  parameter int unsigned            WIDTH     = 8,
  parameter int unsigned            DEPTH     = 2,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
  input  logic                         CLK,
  input  logic                         RN,
  input  logic [WIDTH-1:0]             D,
  input  logic                         DV,
  input  logic                         HOLD,
  input  logic                         FLUSH,
  output logic [WIDTH-1:0]             Q,
  output logic                         QV,
  output logic [$clog2(DEPTH+1)-1:0]   OCC,
  output logic                         PERR
);

  localparam int unsigned OW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [DEPTH-1:0]            v_q;
  logic [DEPTH-1:0]            v_nxt;
  logic [OW-1:0]               occ_q;
  logic [OW-1:0]               occ_nxt;
  logic                        adv;

  // Advance only when neither flush nor hold is active; flush wins over hold.
  assign adv = !FLUSH && !HOLD;

  // Next valid vector and its population count, so OCC moves with v[].
  always_comb begin
    v_nxt   = v_q;
    occ_nxt = '0;
    if (FLUSH) begin
      v_nxt = '0;
    end else if (!HOLD) begin
      v_nxt[0] = DV;
      for (int i = 1; i < int'(DEPTH); i++) begin
        v_nxt[i] = v_q[i-1];
      end
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      occ_nxt = occ_nxt + OW'(v_nxt[i]);
    end
  end

  // Valid flags and occupancy register.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      v_q   <= '0;
      occ_q <= '0;
    end else begin
      v_q   <= v_nxt;
      occ_q <= occ_nxt;
    end
  end

  // Data stages: each stage loads only when its upstream source is valid,
  // so bubbles leave the downstream data untouched.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      data_q <= {DEPTH{RESET_VAL}};
    end else if (adv) begin
      if (DV) begin
        data_q[0] <= D;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (v_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign Q   = data_q[DEPTH-1];
  assign QV  = v_q[DEPTH-1];
  assign OCC = occ_q;

`ifdef DFFRNQ_PIPE_PARITY_EN
  logic [DEPTH-1:0] par_q;

  // Parity bits follow their data under the same load enables.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      par_q <= {DEPTH{^RESET_VAL}};
    end else if (adv) begin
      if (DV) begin
        par_q[0] <= ^D;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (v_q[i-1]) begin
          par_q[i] <= par_q[i-1];
        end
      end
    end
  end

  assign PERR = v_q[DEPTH-1] & ((^data_q[DEPTH-1]) ^ par_q[DEPTH-1]);
`else
  assign PERR = 1'b0;
`endif

endmodule

// File: doc/dffrnq_pipe.md
DFFRNQ_PIPE -- requirements
Module: dffrnq_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data bits per stage (legal 1..64).
REQ-002 SHALL provide parameter DEPTH, default 2, number of register stages (legal 1..16).
REQ-003 SHALL provide parameter RESET_VAL, default 0 (WIDTH bits), data value loaded into every stage on reset.
REQ-004 SHALL have one clock and a synchronous, active-low reset.
REQ-005 SHALL provide ports:
- CLK  input  1  clock; all state changes on rising edge.
- RN  input  1  synchronous active-low reset, sampled at the CLK rising edge.
- D  input  WIDTH  data into stage 0.
- DV  input  1  D is valid this cycle.
- HOLD  input  1  freeze all stages.
- FLUSH  input  1  invalidate all stages.
- Q  output  WIDTH  data of the last stage.
- QV  output  1  valid of the last stage.
- OCC  output  clog2(DEPTH+1)  count of valid stages.
- PERR  output  1  parity error on the last stage.

Function
REQ-006 SHALL hold per stage i (0..DEPTH-1) a WIDTH-bit data register and a 1-bit valid flag v[i].
REQ-007 Each CLK edge SHALL apply exactly one of the following, checked in this priority order:
- RN=0: reset.
- FLUSH=1: all v[i] cleared, all data retained; FLUSH overrides HOLD.
- HOLD=1: all data and valid registers retain.
- Otherwise: advance.
REQ-008 On advance, v[0] SHALL take DV and v[i] SHALL take v[i-1].
REQ-009 On advance, stage-0 data SHALL load D only when DV=1.
REQ-010 On advance, stage-i data SHALL load stage i-1 data only when v[i-1]=1; otherwise it retains.
REQ-011 Q and QV SHALL be driven directly from the last stage, with no combinational path from D, DV, HOLD or FLUSH.
REQ-012 Latency from a DV=1 sample to QV=1 carrying that D SHALL be exactly DEPTH advancing edges; HOLD cycles add one cycle each.
REQ-013 OCC SHALL equal the population count of v[], registered, updated on the same edge as v[].
REQ-014 OCC SHALL never exceed DEPTH, and SHALL read 0 on the edge after a flush.
REQ-015 With DEPTH=1 the block SHALL behave as a single enable-gated register with valid.
REQ-016 Gaps with DV=0 SHALL propagate as bubbles: no data reordering, no duplication, no loss except by FLUSH or reset.

Reset
REQ-017 When RN=0 at a CLK edge, all data registers SHALL load RESET_VAL and all v[i] SHALL clear, regardless of DV, HOLD or FLUSH.
REQ-018 After reset: Q=RESET_VAL, QV=0, OCC=0, PERR=0.
REQ-019 RN SHALL have no effect between clock edges.
REQ-020 Reset asserted mid-stream SHALL discard all in-flight data.
REQ-021 The first advancing edge after RN returns high SHALL accept DV/D normally.

Configuration
REQ-022 Macro DFFRNQ_PIPE_PARITY_EN defined: each stage SHALL carry an extra parity bit.
- Stage 0 captures the even parity of D (XOR of all bits) whenever it loads D.
- The parity bit moves with its data under the same enable, hold, flush and reset rules (reset value = parity of RESET_VAL).
- PERR SHALL equal QV AND (XOR of Q) XOR (stored parity of the last stage).
REQ-023 Macro not defined: no parity storage SHALL be built and PERR SHALL be tied 0.

Verification (WIDTH=8, DEPTH=3, RESET_VAL=8'h00 unless stated)
REQ-024 Reset then stream:
- Stimulus: RN=0 for 1 edge, then D=8'h11, 8'h22, 8'h33 with DV=1 on 3 consecutive edges.
- Required: QV first rises after the 3rd advancing edge with Q=8'h11, followed by 8'h22 and 8'h33; OCC reads 1, 2, 3.
REQ-025 Hold:
- Stimulus: pipeline full (8'hA1, 8'hA2, 8'hA3), HOLD=1 for 4 edges with DV=1 and D=8'hFF.
- Required: Q, QV and OCC unchanged for all 4 edges; 8'hFF never appears on Q.
REQ-026 Flush beats hold:
- Stimulus: full pipeline, FLUSH=1 and HOLD=1 on the same edge.
- Required: next cycle QV=0 and OCC=0; Q retains its previous data value.
REQ-027 Bubbles:
- Stimulus: DV pattern 1,0,1 with D=8'h05, 8'hEE, 8'h07.
- Required: QV pattern 1,0,1 with Q=8'h05, then 8'h05 retained, then 8'h07.
REQ-028 Reset mid-stream:
- Stimulus: RN=0 on one edge while OCC=2, with RESET_VAL=8'h5A.
- Required: next cycle Q=8'h5A, QV=0, OCC=0.
REQ-029 Parity, with DFFRNQ_PIPE_PARITY_EN defined:
- Stimulus: force-flip bit 0 of the last-stage data while QV=1, Q=8'h0F.
- Required: PERR=1 that cycle.
- Without the macro: PERR stays 0.
